// File: rtl/mvm.sv
// Tiled signed matrix-vector multiplier: result[c] = sum_r vector[r] * matrix[r][c].
// Columns are processed in groups of TILING_ROW, each group consuming TILING_COL rows per cycle.
module mvm #(
  parameter int unsigned MATRIX_WIDTH      = 20,
  parameter int unsigned MATRIX_HEIGHT     = 5,
  parameter int unsigned VECTOR_CELL_WIDTH = 8,
  parameter int unsigned MATRIX_CELL_WIDTH = 8,
  parameter int unsigned TILING_ROW        = 1,
  parameter int unsigned TILING_COL        = 1,
  localparam int unsigned RESULT_WIDTH =
    VECTOR_CELL_WIDTH + MATRIX_CELL_WIDTH + $clog2(MATRIX_HEIGHT) + 1
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    start,
  input  logic [MATRIX_HEIGHT*VECTOR_CELL_WIDTH-1:0]              vector,
  input  logic [MATRIX_WIDTH*MATRIX_HEIGHT*MATRIX_CELL_WIDTH-1:0] matrix,
  output logic [MATRIX_WIDTH*RESULT_WIDTH-1:0]                    result,
  output logic                                                    valid
);

  localparam int unsigned VEC_BITS  = MATRIX_HEIGHT * VECTOR_CELL_WIDTH;
  localparam int unsigned MAT_BITS  = MATRIX_WIDTH * MATRIX_HEIGHT * MATRIX_CELL_WIDTH;
  localparam int unsigned PROD_W    = VECTOR_CELL_WIDTH + MATRIX_CELL_WIDTH;
  localparam int unsigned ROW_STEPS = (MATRIX_HEIGHT + TILING_COL - 1) / TILING_COL;
  localparam int unsigned GROUPS    = (MATRIX_WIDTH + TILING_ROW - 1) / TILING_ROW;
  localparam int unsigned RCW       = $clog2(ROW_STEPS + 1);
  localparam int unsigned GCW       = $clog2(GROUPS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                         state;
  logic [VEC_BITS-1:0]            vec_q;
  logic [MAT_BITS-1:0]            mat_q;
  logic [RCW-1:0]                 row_cnt;
  logic [GCW-1:0]                 grp_cnt;
  logic                           drain;
  logic signed [RESULT_WIDTH-1:0] acc [TILING_ROW];
  logic signed [RESULT_WIDTH-1:0] sum [TILING_ROW];
  logic [31:0]                    row_base;
  logic [31:0]                    col_base;
  logic                           row_last;
  logic                           grp_last;

  // One sign-extended product; cells outside the matrix contribute zero.
  function automatic logic signed [RESULT_WIDTH-1:0] mac_term(
    input logic [VEC_BITS-1:0] v,
    input logic [MAT_BITS-1:0] m,
    input int unsigned         r,
    input int unsigned         c
  );
    logic signed [VECTOR_CELL_WIDTH-1:0] a;
    logic signed [MATRIX_CELL_WIDTH-1:0] b;
    logic signed [PROD_W-1:0]            p;
    mac_term = '0;
    if (r < MATRIX_HEIGHT && c < MATRIX_WIDTH) begin
      a        = v[r*VECTOR_CELL_WIDTH +: VECTOR_CELL_WIDTH];
      b        = m[(r*MATRIX_WIDTH + c)*MATRIX_CELL_WIDTH +: MATRIX_CELL_WIDTH];
      p        = PROD_W'(a) * PROD_W'(b);
      mac_term = RESULT_WIDTH'(p);
    end
  endfunction

  // Partial sums for the current tile.
  always_comb begin
    row_base = 32'(row_cnt) * TILING_COL;
    col_base = 32'(grp_cnt) * TILING_ROW;
    row_last = (row_cnt == RCW'(ROW_STEPS - 1));
    grp_last = (grp_cnt == GCW'(GROUPS - 1));
    for (int unsigned i = 0; i < TILING_ROW; i++) begin
      sum[i] = acc[i];
      for (int unsigned j = 0; j < TILING_COL; j++) begin
        sum[i] = sum[i] + mac_term(vec_q, mat_q, row_base + j, col_base + i);
      end
    end
  end

  // drain marks the spare cycle between the last group write and the valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      valid   <= 1'b0;
      result  <= '0;
      vec_q   <= '0;
      mat_q   <= '0;
      row_cnt <= '0;
      grp_cnt <= '0;
      drain   <= 1'b0;
      for (int unsigned i = 0; i < TILING_ROW; i++) acc[i] <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec_q   <= vector;
            mat_q   <= matrix;
            row_cnt <= '0;
            grp_cnt <= '0;
            drain   <= 1'b0;
            for (int unsigned i = 0; i < TILING_ROW; i++) acc[i] <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (drain) begin
            valid <= 1'b1;
            drain <= 1'b0;
            state <= IDLE;
          end else if (row_last) begin
            row_cnt <= '0;
            for (int unsigned i = 0; i < TILING_ROW; i++) begin
              acc[i] <= '0;
              if (col_base + i < MATRIX_WIDTH)
                result[(col_base + i)*RESULT_WIDTH +: RESULT_WIDTH] <= sum[i];
            end
            if (grp_last) drain <= 1'b1;
            else          grp_cnt <= grp_cnt + GCW'(1);
          end else begin
            row_cnt <= row_cnt + RCW'(1);
            for (int unsigned i = 0; i < TILING_ROW; i++) acc[i] <= sum[i];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm.sv
// Self-checking bench for mvm: three tilings run side by side against a behavioural model
// that tracks expected result/valid every cycle, plus literal checks of known products.
module tb_mvm;

  localparam int MW = 20;
  localparam int MH = 5;
  localparam int CW = 8;
  localparam int RW = 20;
  localparam int VB = MH * CW;
  localparam int MB = MW * MH * CW;
  localparam int RB = MW * RW;
  localparam int ND = 3;
  localparam int TRS [ND] = '{1, 4, 3};
  localparam int TCS [ND] = '{1, 5, 2};
  localparam int LAT [ND] = '{101, 6, 22};

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [VB-1:0] vector;
  logic [MB-1:0] matrix;
  logic [RB-1:0] res [ND];
  logic [ND-1:0] vld;

  int n_vec = 0;
  int n_err = 0;

  mvm u0 (.clk(clk), .rst(rst), .start(start), .vector(vector), .matrix(matrix),
          .result(res[0]), .valid(vld[0]));
  mvm #(.TILING_ROW(4), .TILING_COL(5)) u1 (
          .clk(clk), .rst(rst), .start(start), .vector(vector), .matrix(matrix),
          .result(res[1]), .valid(vld[1]));
  mvm #(.TILING_ROW(3), .TILING_COL(2)) u2 (
          .clk(clk), .rst(rst), .start(start), .vector(vector), .matrix(matrix),
          .result(res[2]), .valid(vld[2]));

  always #5 clk = ~clk;

  task automatic chk_bus(input string name, input logic [RB-1:0] act, input logic [RB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference dot product of column c, plain signed integer arithmetic.
  function automatic int dot(input logic [VB-1:0] v, input logic [MB-1:0] m, input int c);
    int s = 0;
    for (int r = 0; r < MH; r++)
      s += int'($signed(v[r*CW +: CW])) * int'($signed(m[(r*MW + c)*CW +: CW]));
    return s;
  endfunction

  // Behavioural model: per-instance expected result columns and valid.
  int full_m [ND][MW];
  int old_m  [ND][MW];
  int cur_m  [ND][MW];
  int e_m    [ND];
  bit busy_m [ND];
  bit vexp   [ND];

  always @(posedge clk or negedge rst) begin : model
    int rs, n, cols;
    if (!rst) begin
      for (int d = 0; d < ND; d++) begin
        busy_m[d] = 1'b0;
        vexp[d]   = 1'b0;
        e_m[d]    = 0;
        for (int c = 0; c < MW; c++) begin
          cur_m[d][c]  = 0;
          old_m[d][c]  = 0;
          full_m[d][c] = 0;
        end
      end
    end else begin
      for (int d = 0; d < ND; d++) begin
        rs      = (MH + TCS[d] - 1) / TCS[d];
        n       = ((MW + TRS[d] - 1) / TRS[d]) * rs;
        vexp[d] = 1'b0;
        if (busy_m[d]) begin
          e_m[d]++;
          cols = (e_m[d] / rs) * TRS[d];
          if (cols > MW) cols = MW;
          for (int c = 0; c < MW; c++)
            cur_m[d][c] = (c < cols) ? full_m[d][c] : old_m[d][c];
          if (e_m[d] == n + 1) begin
            busy_m[d] = 1'b0;
            vexp[d]   = 1'b1;
          end
        end else if (start) begin
          busy_m[d] = 1'b1;
          e_m[d]    = 0;
          for (int c = 0; c < MW; c++) begin
            old_m[d][c]  = cur_m[d][c];
            full_m[d][c] = dot(vector, matrix, c);
          end
        end
      end
    end
  end

  // Per-cycle compare of every instance against the model.
  always @(negedge clk) begin
    logic [RB-1:0] exp;
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < MW; c++) exp[c*RW +: RW] = RW'(cur_m[d][c]);
      chk_bus($sformatf("u%0d result", d), res[d], exp);
      chk_bit($sformatf("u%0d valid", d), vld[d], vexp[d]);
    end
  end

  // Pulse start, optionally re-pulse with other data, and measure each valid latency.
  task automatic run_op(input logic [VB-1:0] v, input logic [MB-1:0] m, input int restart_at);
    int lat [ND];
    int k;
    vector = v;
    matrix = m;
    start  = 1'b1;
    @(posedge clk);
    #3 start = 1'b0;
    for (int d = 0; d < ND; d++) lat[d] = -1;
    k = 0;
    while (k < 200 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0)) begin
      @(posedge clk);
      k++;
      #1;
      for (int d = 0; d < ND; d++) if (vld[d] === 1'b1 && lat[d] < 0) lat[d] = k;
      if (restart_at > 0 && k == restart_at) begin
        #2;
        start  = 1'b1;
        vector = ~v;
        matrix = ~m;
      end else if (restart_at > 0 && k == restart_at + 1) begin
        #2 start = 1'b0;
      end
    end
    #2;
    for (int d = 0; d < ND; d++) chk_int($sformatf("u%0d latency", d), lat[d], LAT[d]);
  endtask

  task automatic check_seq(input string tag);
    logic [RB-1:0] exp;
    for (int c = 0; c < MW; c++) exp[c*RW +: RW] = RW'(815 + 15*c);
    for (int d = 0; d < ND; d++) chk_bus($sformatf("%s u%0d", tag, d), res[d], exp);
  endtask

  logic [VB-1:0] seq_v;
  logic [MB-1:0] seq_m;
  logic [VB-1:0] neg_v;
  logic [MB-1:0] neg_m;
  logic [RB-1:0] neg_exp;
  logic [VB-1:0] rnd_v;
  logic [MB-1:0] rnd_m;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit saw;
    rst    = 1'b0;
    start  = 1'b0;
    vector = '0;
    matrix = '0;
    for (int r = 0; r < MH; r++) seq_v[r*CW +: CW] = CW'(r + 1);
    for (int k = 0; k < MW*MH; k++) seq_m[k*CW +: CW] = CW'(k + 1);
    neg_v = '0;
    neg_v[CW-1:0] = 8'h80;
    neg_m = '0;
    for (int r = 0; r < MH; r++) neg_m[(r*MW)*CW +: CW] = 8'h80;
    neg_exp = '0;
    neg_exp[RW-1:0] = 20'd16384;

    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk_bus($sformatf("reset result u%0d", d), res[d], '0);
      chk_bit($sformatf("reset valid u%0d", d), vld[d], 1'b0);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    run_op(seq_v, seq_m, 0);
    check_seq("seq");

    run_op(neg_v, neg_m, 0);
    for (int d = 0; d < ND; d++) chk_bus($sformatf("neg u%0d", d), res[d], neg_exp);

    run_op(seq_v, seq_m, 3);
    check_seq("restart ignored");

    // Abort an operation with reset at cycle 50.
    vector = seq_v;
    matrix = seq_m;
    start  = 1'b1;
    @(posedge clk);
    #3 start = 1'b0;
    repeat (50) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk_bus($sformatf("abort result u%0d", d), res[d], '0);
      chk_bit($sformatf("abort valid u%0d", d), vld[d], 1'b0);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    saw = 1'b0;
    repeat (120) begin
      @(posedge clk);
      #1;
      if (vld !== '0) saw = 1'b1;
    end
    #2;
    chk_bit("no valid after abort", saw, 1'b0);

    run_op(seq_v, seq_m, 0);
    check_seq("after abort");

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < VB; i += 8) rnd_v[i +: 8] = 8'($urandom);
      for (int i = 0; i < MB; i += 32) rnd_m[i +: 32] = $urandom;
      run_op(rnd_v, rnd_m, int'($urandom_range(0, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
